// File: rtl/nios_debug_slave_cmd_engine_if.sv
// Virtual-JTAG DR scan strobes and serial data between the strobe synchroniser and the debug slave.
interface nios_debug_slave_cmd_engine_if #(
  parameter int IR_W = 2
);
  logic [IR_W-1:0] ir_in;
  logic            vs_cdr;
  logic            vs_sdr;
  logic            vs_udr;
  logic            tdi;
  logic            tdo;

  modport master (output ir_in, vs_cdr, vs_sdr, vs_udr, tdi, input tdo);
  modport slave  (input ir_in, vs_cdr, vs_sdr, vs_udr, tdi, output tdo);
endinterface

// File: rtl/nios_debug_slave_cmd_engine.sv
// Nios debug-slave DR scan engine: capture readback, shift, update to jdo and action strobes.
// Optional even-parity bit on the scan word enabled by defining DEBUG_SLAVE_PARITY_EN.
module nios_debug_slave_cmd_engine #(
  parameter  int IR_W   = 2,
  parameter  int DATA_W = 36,
  localparam int NUM_CH = 1 << IR_W,
`ifdef DEBUG_SLAVE_PARITY_EN
  localparam int DR_W   = DATA_W + 3
`else
  localparam int DR_W   = DATA_W + 2
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  nios_debug_slave_cmd_engine_if.slave jtag,
  input  logic [NUM_CH*DATA_W-1:0]   rd_data,
  input  logic [1:0]                 status,
  input  logic                       err_clr,
  output logic [DR_W-1:0]            jdo,
  output logic [NUM_CH-1:0]          take_action,
  output logic [NUM_CH-1:0]          take_no_action,
  output logic                       scan_err,
  output logic                       parity_err
);

  localparam int CNT_W = $clog2(DR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DR_W-1:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic [IR_W-1:0]   ir_lat;
  logic [DATA_W-1:0] cap_data;
  logic [DR_W-1:0]   cap_word;
  logic [NUM_CH-1:0] ch_onehot;
  logic              do_shift, do_update, len_ok, par_ok, accept;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (jtag.ir_in == IR_W'(k)) cap_data = rd_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef DEBUG_SLAVE_PARITY_EN
  assign cap_word = {^{status, cap_data}, status, cap_data};
  assign par_ok   = ~^sr;
`else
  assign cap_word = {status, cap_data};
  assign par_ok   = 1'b1;
`endif

  // Capture outranks update, update outranks shift; only SHIFT reacts to sdr/udr.
  always_comb begin
    state_d   = state_q;
    do_shift  = 1'b0;
    do_update = 1'b0;
    if (jtag.vs_cdr) begin
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (jtag.vs_udr) begin
        state_d   = IDLE;
        do_update = 1'b1;
      end else if (jtag.vs_sdr) begin
        do_shift = 1'b1;
      end
    end
  end

  assign len_ok    = (cnt == CNT_FULL);
  assign accept    = do_update && len_ok && par_ok;
  assign ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << ir_lat;
  assign jtag.tdo  = sr[0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sr             <= '0;
      cnt            <= '0;
      ir_lat         <= '0;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      scan_err       <= 1'b0;
    end else begin
      state_q        <= state_d;
      take_action    <= '0;
      take_no_action <= '0;
      if (jtag.vs_cdr) begin
        ir_lat <= jtag.ir_in;
        sr     <= cap_word;
        cnt    <= '0;
      end else if (do_shift) begin
        sr <= {jtag.tdi, sr[DR_W-1:1]};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
      if (accept) begin
        jdo <= sr;
        if (sr[DATA_W+1]) take_action    <= ch_onehot;
        else              take_no_action <= ch_onehot;
      end
      // A set event in the same cycle as err_clr keeps the flag set.
      if (do_update && !len_ok) scan_err <= 1'b1;
      else if (err_clr)         scan_err <= 1'b0;
    end
  end

`ifdef DEBUG_SLAVE_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)                            parity_err <= 1'b0;
    else if (do_update && len_ok && !par_ok) parity_err <= 1'b1;
    else if (err_clr)                     parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios_debug_slave_cmd_engine.sv
// Scoreboard bench for nios_debug_slave_cmd_engine: expected pulses/tdo bits queued by stimulus, checked by a monitor.
module tb_nios_debug_slave_cmd_engine;
  localparam int IR_W   = 2;
  localparam int DATA_W = 36;
  localparam int NUM_CH = 4;
`ifdef DEBUG_SLAVE_PARITY_EN
  localparam int DR_W   = DATA_W + 3;
`else
  localparam int DR_W   = DATA_W + 2;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [1:0]               status;
  logic                     err_clr;
  logic [DR_W-1:0]          jdo;
  logic [NUM_CH-1:0]        take_action, take_no_action;
  logic                     scan_err, parity_err;

  nios_debug_slave_cmd_engine_if #(.IR_W(IR_W)) jtag ();

  nios_debug_slave_cmd_engine #(.IR_W(IR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .jtag           (jtag),
    .rd_data        (rd_data),
    .status         (status),
    .err_clr        (err_clr),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .scan_err       (scan_err),
    .parity_err     (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] act_v;
    logic [NUM_CH-1:0] noact_v;
    logic [DR_W-1:0]   word;
  } exp_t;

  exp_t            exp_q[$];
  logic            tdo_q[$];
  exp_t            mon_e;
  logic            mon_b;
  int              n_pass  = 0;
  int              n_total = 0;
  logic [DR_W-1:0] last_jdo;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [DR_W-1:0] mk_word(input logic a, input logic s, input logic [DATA_W-1:0] p);
`ifdef DEBUG_SLAVE_PARITY_EN
    return {^{a, s, p}, a, s, p};
`else
    return {a, s, p};
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cdr(input logic [IR_W-1:0] ir);
    jtag.ir_in  = ir;
    jtag.vs_cdr = 1'b1;
    cyc();
    jtag.vs_cdr = 1'b0;
  endtask

  task automatic shift_bits(input logic [DR_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      jtag.vs_sdr = 1'b1;
      jtag.tdi    = (i < DR_W) ? w[i] : 1'b0;
      cyc();
    end
    jtag.vs_sdr = 1'b0;
    jtag.tdi    = 1'b0;
  endtask

  task automatic do_udr();
    jtag.vs_udr = 1'b1;
    cyc();
    jtag.vs_udr = 1'b0;
  endtask

  task automatic expect_pulse(input int ch, input logic [DR_W-1:0] w);
    exp_t e;
    logic [NUM_CH-1:0] oh;
    oh     = NUM_CH'(1) << ch;
    e.word = w;
    if (w[DATA_W+1]) begin e.act_v = oh;  e.noact_v = '0; end
    else             begin e.act_v = '0;  e.noact_v = oh; end
    exp_q.push_back(e);
    last_jdo = w;
  endtask

  // Monitor: any pulse must match the oldest queued expectation; tdo checked on shift cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (take_action != '0 || take_no_action != '0) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse: take_action=%b take_no_action=%b, expected no pulse",
                   take_action, take_no_action);
        end else begin
          mon_e = exp_q.pop_front();
          check("take_action", 64'(take_action), 64'(mon_e.act_v));
          check("take_no_action", 64'(take_no_action), 64'(mon_e.noact_v));
          check("jdo", 64'(jdo), 64'(mon_e.word));
        end
      end
      if (jtag.vs_sdr && tdo_q.size() > 0) begin
        mon_b = tdo_q.pop_front();
        check("tdo_bit", 64'(jtag.tdo), 64'(mon_b));
      end
    end
  end

  logic [DR_W-1:0]   w;
  logic [DATA_W-1:0] rb;

  initial begin
    reset       = 1'b1;
    err_clr     = 1'b0;
    status      = 2'b01;
    jtag.ir_in  = '0;
    jtag.vs_cdr = 1'b0;
    jtag.vs_sdr = 1'b0;
    jtag.vs_udr = 1'b0;
    jtag.tdi    = 1'b0;
    last_jdo    = '0;
    rd_data     = {36'h3_3333_3333, 36'hA_5A5A_5A5A, 36'h1_1111_1111, 36'h0_0000_0000};
    repeat (3) cyc();

    check("rst_tdo", 64'(jtag.tdo), 64'h0);
    check("rst_jdo", 64'(jdo), 64'h0);
    check("rst_take_action", 64'(take_action), 64'h0);
    check("rst_take_no_action", 64'(take_no_action), 64'h0);
    check("rst_scan_err", 64'(scan_err), 64'h0);
    check("rst_parity_err", 64'(parity_err), 64'h0);
    reset = 1'b0;
    cyc();

    // Full write scan on channel 1, act=1
    w = mk_word(1'b1, 1'b0, 36'h9_8765_4321);
    expect_pulse(1, w);
    do_cdr(2'd1); shift_bits(w, DR_W); do_udr();
    check("t1_jdo_payload", 64'(jdo[DATA_W-1:0]), 64'h9_8765_4321);
    check("t1_take_action", 64'(take_action), 64'b0010);
    cyc();
    check("t1_pulse_one_clk", 64'(take_action), 64'h0);

    // More patterns: ch3 act=0, ch0 act=1 all-ones payload
    w = mk_word(1'b0, 1'b1, 36'h0_0000_00FF);
    expect_pulse(3, w);
    do_cdr(2'd3); shift_bits(w, DR_W); do_udr(); cyc();
    w = mk_word(1'b1, 1'b1, 36'hF_FFFF_FFFF);
    expect_pulse(0, w);
    do_cdr(2'd0); shift_bits(w, DR_W); do_udr(); cyc();

    // Readback on channel 2: data LSB first, then status[0]=1, status[1]=0
    rb = 36'hA_5A5A_5A5A;
    for (int i = 0; i < DATA_W; i++) tdo_q.push_back(rb[i]);
    tdo_q.push_back(1'b1);
    tdo_q.push_back(1'b0);
`ifdef DEBUG_SLAVE_PARITY_EN
    tdo_q.push_back(^{2'b01, rb});
`endif
    expect_pulse(2, '0);
    do_cdr(2'd2); shift_bits('0, DR_W); do_udr(); cyc();

    // Short scan -> scan_err, jdo holds; then clear
    do_cdr(2'd0); shift_bits('1, DR_W - 1); do_udr();
    check("short_scan_err", 64'(scan_err), 64'h1);
    check("short_jdo_hold", 64'(jdo), 64'(last_jdo));
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("err_clr", 64'(scan_err), 64'h0);

    // Set and clear in the same clk: set wins
    do_cdr(2'd0); shift_bits('1, DR_W - 1);
    err_clr = 1'b1; do_udr(); err_clr = 1'b0;
    check("set_beats_clr", 64'(scan_err), 64'h1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // Over-long scan (counter saturates, no wrap back to DR_W)
    do_cdr(2'd1); shift_bits('0, 45); do_udr();
    check("long_scan_err", 64'(scan_err), 64'h1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // cdr+udr same clk -> capture wins; a full scan afterwards is accepted
    jtag.ir_in  = 2'd3;
    jtag.vs_cdr = 1'b1;
    jtag.vs_udr = 1'b1;
    cyc();
    jtag.vs_cdr = 1'b0;
    jtag.vs_udr = 1'b0;
    check("cdr_udr_no_err", 64'(scan_err), 64'h0);
    w = mk_word(1'b1, 1'b1, 36'h1_2345_6789);
    expect_pulse(3, w);
    shift_bits(w, DR_W); do_udr(); cyc();

    // Update while IDLE is ignored
    do_udr();
    check("idle_udr_no_err", 64'(scan_err), 64'h0);
    check("idle_udr_jdo_hold", 64'(jdo), 64'(last_jdo));

    // Re-capture mid-scan restarts the count without error
    do_cdr(2'd2); shift_bits('1, 10);
    w = mk_word(1'b0, 1'b0, 36'h5_0505_0505);
    expect_pulse(0, w);
    do_cdr(2'd0); shift_bits(w, DR_W); do_udr(); cyc();
    check("recapture_no_err", 64'(scan_err), 64'h0);

    // Reset after 20 shifts aborts the scan
    do_cdr(2'd1); shift_bits(mk_word(1'b1, 1'b0, 36'hC_CCCC_CCCC), 20);
    reset = 1'b1; cyc();
    check("midrst_tdo", 64'(jtag.tdo), 64'h0);
    check("midrst_jdo", 64'(jdo), 64'h0);
    check("midrst_take_action", 64'(take_action), 64'h0);
    check("midrst_take_no_action", 64'(take_no_action), 64'h0);
    check("midrst_scan_err", 64'(scan_err), 64'h0);
    check("midrst_parity_err", 64'(parity_err), 64'h0);
    reset    = 1'b0;
    last_jdo = '0;
    do_udr(); cyc();
    check("post_rst_udr_no_err", 64'(scan_err), 64'h0);
    check("post_rst_jdo", 64'(jdo), 64'h0);

`ifdef DEBUG_SLAVE_PARITY_EN
    // Parity: flipped payload bit rejected, correct word accepted
    w = mk_word(1'b0, 1'b0, 36'h0_F0F0_F0F0);
    do_cdr(2'd1); shift_bits(w ^ (DR_W'(1) << 5), DR_W); do_udr();
    check("par_err_set", 64'(parity_err), 64'h1);
    check("par_no_scan_err", 64'(scan_err), 64'h0);
    check("par_jdo_hold", 64'(jdo), 64'(last_jdo));
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("par_err_clr", 64'(parity_err), 64'h0);
    expect_pulse(1, w);
    do_cdr(2'd1); shift_bits(w, DR_W); do_udr();
    check("par_ok_take_no_action", 64'(take_no_action), 64'b0010);
    cyc();
`else
    check("parity_err_tied", 64'(parity_err), 64'h0);
`endif

    repeat (3) cyc();
    check("pulse_queue_drained", 64'(exp_q.size()), 64'h0);
    check("tdo_queue_drained", 64'(tdo_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
